tt_bist_harness: RTL and testbench

//  On-chip built-in self-test harness for a tt_um_* user project: pseudo-random stimulus
//  and response compaction on silicon instead of a cocotb bench. Drives DUT inputs from a

---
 rtl/tt_bist_harness.sv | 138 +++++++++++++
 tb/tb_tt_bist_harness.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_bist_harness.sv
// On-chip BIST harness: Galois LFSR stimulus, MISR response compaction, golden compare.
// Latency: run takes NUM_PATTERNS+LATENCY busy cycles plus one DONE cycle; pass valid after done.
// Backpressure: none; ena=0 freezes every register, start is honoured only in IDLE.
// Optional feature macro: BIST_STICKY_FAIL_EN (sticky fail flag held until reset).
module tt_bist_harness #(
  parameter int          DATA_W       = 8,
  parameter int          RESP_W       = 8,
  parameter int          SIG_W        = 16,
  parameter int          NUM_PATTERNS = 256,
  parameter int          LATENCY      = 1,
  parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED = 8'h01,
  parameter logic [SIG_W-1:0]  MISR_POLY = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [SIG_W-1:0]  golden,
  input  logic [RESP_W-1:0] resp_in,
  output logic [DATA_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic              fail_sticky
);

  localparam int CNT_W = $clog2(NUM_PATTERNS + LATENCY + 1);
  // An all-zero seed would lock the LFSR at zero, so it is promoted to 1.
  localparam logic [DATA_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_lfsr;
  logic [SIG_W-1:0]   r_sig;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pass;
  logic               w_launch;
  logic               w_busy;
  logic               w_done;
  logic               w_last;
  logic               w_stim_act;
  logic               w_compact;
  logic [DATA_W-1:0]  w_lfsr_nxt;
  logic [SIG_W-1:0]   w_sig_nxt;

  assign w_last     = (r_cnt == CNT_W'(NUM_PATTERNS + LATENCY - 1));
  assign w_stim_act = w_busy && (r_cnt < CNT_W'(NUM_PATTERNS));
  // Responses only become meaningful once the DUT pipeline has filled.
  assign w_compact  = (r_cnt >= CNT_W'(LATENCY));
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
  assign w_sig_nxt  = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                    ^ SIG_W'(resp_in);

  // State register; ena low holds the FSM in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded control.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_launch    = 1'b1;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: LFSR, MISR, pattern counter and the pass verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_EFF;
      r_sig  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (ena) begin
      if (w_launch) begin
        r_lfsr <= SEED_EFF;
        r_sig  <= '0;
        r_cnt  <= '0;
        r_pass <= 1'b0;
      end
      if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_stim_act) r_lfsr <= w_lfsr_nxt;
        if (w_compact)  r_sig  <= w_sig_nxt;
      end
      if (w_done) r_pass <= (r_sig == golden);
    end
  end

`ifdef BIST_STICKY_FAIL_EN
  logic r_fail;

  // Any mismatching run latches the failure until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail <= 1'b0;
    end else if (ena && w_done && (r_sig != golden)) begin
      r_fail <= 1'b1;
    end
  end

  assign fail_sticky = r_fail;
`else
  assign fail_sticky = 1'b0;
`endif

  assign stim_out  = w_stim_act ? r_lfsr : '0;
  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: table-driven FSM sequence plus model-checked runs.
// Runs cover loopback, random responses, start during RUN/DONE, ena freeze, mid-run reset.
// Expected signatures come from a per-cycle MISR fold of the responses the bench applies.
module tb_tt_bist_harness;

  localparam int DW = 4;
  localparam int RW = 4;
  localparam int SW = 8;
  localparam int NP = 4;
  localparam int LAT = 1;
  localparam logic [SW-1:0] MPOLY = 8'h1D;
`ifdef BIST_STICKY_FAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          start;
  logic [SW-1:0] golden;
  logic [RW-1:0] resp_in;
  logic [DW-1:0] stim_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [SW-1:0] signature;
  logic          fail_sticky;

  int total = 0;
  int bad   = 0;
  bit sticky_exp = 1'b0;

  // Stimulus expected from the LFSR with poly C and seed 1.
  logic [DW-1:0] exp_stim [0:7];

  tt_bist_harness #(
    .DATA_W(DW), .RESP_W(RW), .SIG_W(SW), .NUM_PATTERNS(NP), .LATENCY(LAT),
    .LFSR_POLY(4'hC), .LFSR_SEED(4'h1), .MISR_POLY(MPOLY)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .golden(golden),
    .resp_in(resp_in), .stim_out(stim_out), .busy(busy), .done(done),
    .pass(pass), .signature(signature), .fail_sticky(fail_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One compaction step: shift left, fold in feedback, xor the response.
  function automatic logic [SW-1:0] misr(input logic [SW-1:0] s, input logic [RW-1:0] r);
    logic [SW-1:0] fb;
    fb = s[SW-1] ? MPOLY : 8'h00;
    return ((s << 1) & 8'hFF) ^ fb ^ {4'h0, r};
  endfunction

  // Start one run from IDLE and follow it to completion, checking as it goes.
  task automatic run(input bit loopback, input bit pulse_start, input int freeze_at,
                     input bit want_fail, output logic [SW-1:0] dut_sig);
    logic [SW-1:0] msig;
    logic [DW-1:0] prev;
    logic [RW-1:0] r;
    logic [DW-1:0] snap_s;
    logic [SW-1:0] snap_g;
    int c, nbusy, ndone;
    bit pend;
    msig = '0; prev = '0; c = 0; nbusy = 0; ndone = 0; pend = 1'b0; dut_sig = '0;
    ena = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NP + LAT + 6; k++) begin
      if (busy && k == freeze_at) begin
        snap_s = stim_out;
        snap_g = signature;
        ena = 1'b0;
        repeat (3) begin
          resp_in = 4'($urandom);
          @(negedge clk);
          chk("freeze_stim", 32'(stim_out), 32'(snap_s));
          chk("freeze_sig", 32'(signature), 32'(snap_g));
        end
        ena = 1'b1;
      end
      if (pend) begin
        chk("pass", 32'(pass), 32'(!want_fail));
        chk("fail_sticky", 32'(fail_sticky), 32'(sticky_exp));
        pend = 1'b0;
      end
      if (busy) begin
        nbusy++;
        chk("stim", 32'(stim_out), 32'((c < NP) ? exp_stim[c] : 4'h0));
        r = loopback ? prev : 4'($urandom);
        resp_in = r;
        if (c >= LAT) msig = misr(msig, r);
        prev = stim_out;
        c++;
      end
      if (done) begin
        ndone++;
        chk("signature", 32'(signature), 32'(msig));
        dut_sig = signature;
        golden = msig ^ SW'(want_fail);
        if (want_fail && STICKY) sticky_exp = 1'b1;
        pend = 1'b1;
      end
      if (pulse_start) start = (k == 2) || done;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", 32'(nbusy), 32'(NP + LAT));
    chk("done_pulses", 32'(ndone), 32'd1);
  endtask

  typedef struct {
    logic       ena;
    logic       start;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_stim;
  } vec_t;

  vec_t tab [0:8];
  logic [SW-1:0] sig_ref;
  logic [SW-1:0] s;

  initial begin
    exp_stim[0] = 4'h1; exp_stim[1] = 4'hC; exp_stim[2] = 4'h6; exp_stim[3] = 4'h3;
    exp_stim[4] = 4'h0; exp_stim[5] = 4'h0; exp_stim[6] = 4'h0; exp_stim[7] = 4'h0;
    tab[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h1};
    tab[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'hC};
    tab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h6};
    tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3};
    tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    tab[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    tab[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tab[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tab[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    rst_n = 1'b0; ena = 1'b0; start = 1'b0; golden = '0; resp_in = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_stim", 32'(stim_out), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_fail_sticky", 32'(fail_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-by-cycle walk through a run with zero responses.
    for (int i = 0; i < 9; i++) begin
      ena = tab[i].ena;
      start = tab[i].start;
      @(negedge clk);
      chk($sformatf("tab%0d_busy", i), 32'(busy), 32'(tab[i].exp_busy));
      chk($sformatf("tab%0d_done", i), 32'(done), 32'(tab[i].exp_done));
      chk($sformatf("tab%0d_stim", i), 32'(stim_out), 32'(tab[i].exp_stim));
    end
    start = 1'b0;

    // Loopback runs: pass, fail, then pass again after the failure.
    run(1'b1, 1'b0, -1, 1'b0, sig_ref);
    run(1'b1, 1'b0, -1, 1'b1, s);
    run(1'b1, 1'b0, -1, 1'b0, s);
    // start pulses during RUN and DONE must not disturb the run.
    run(1'b1, 1'b1, -1, 1'b0, s);
    chk("pulse_vs_clean", 32'(s), 32'(sig_ref));
    // Three-cycle ena freeze mid-run.
    run(1'b1, 1'b0, 2, 1'b0, s);
    chk("freeze_vs_clean", 32'(s), 32'(sig_ref));

    // Asynchronous reset between edges in the middle of a run.
    ena = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp_in = 4'hA;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stim", 32'(stim_out), 32'd0);
    chk("midrst_sig", 32'(signature), 32'd0);
    chk("midrst_fail_sticky", 32'(fail_sticky), 32'd0);
    sticky_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b1, 1'b0, -1, 1'b0, s);
    chk("rst_vs_clean", 32'(s), 32'(sig_ref));

    // Random responses with random verdicts and occasional freezes.
    for (int n = 0; n < 10; n++) begin
      run(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 8),
          1'($urandom_range(0, 1)), s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
